// File: rtl/mem_access_if.sv
// Access-size codes and the request/bus interface shared by the memory access
// unit and its environment.
package mem_access_pkg;
  typedef enum logic [2:0] {
    NOT_MEM = 3'd0,
    MEM_B   = 3'd1,
    MEM_BU  = 3'd2,
    MEM_H   = 3'd3,
    MEM_HU  = 3'd4,
    MEM_W   = 3'd5
  } mem_sel_e;
endpackage

interface mem_access_if;
  logic        req_valid;
  logic [2:0]  mem_sel;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        addr_err;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport slave (
    input  req_valid, mem_sel, mem_wen, mem_addr, mem_wdata, bus_ack, bus_rdata,
    output stall, load_data, load_valid, addr_err, bus_err,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );

  modport master (
    output req_valid, mem_sel, mem_wen, mem_addr, mem_wdata, bus_ack, bus_rdata,
    input  stall, load_data, load_valid, addr_err, bus_err,
           bus_req, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_access.sv
// Data-memory access unit: aligns byte/half/word accesses onto a word bus,
// waits for ack with a timeout, and returns extended load data.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  m
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state, state_next;
  logic [CW-1:0] wait_cnt;

  logic        is_mem, misaligned, active, accept, timeout;
  logic        sel_byte, sel_half, sel_signed;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic [1:0]  cap_off;
  logic        cap_byte, cap_half, cap_signed;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] rd_ext;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    is_mem     = 1'b0;
    misaligned = 1'b0;
    sel_byte   = 1'b0;
    sel_half   = 1'b0;
    sel_signed = 1'b0;
    be_next    = 4'b0000;
    wdata_next = 32'h0;
    case (m.mem_sel)
      MEM_B, MEM_BU: begin
        is_mem     = 1'b1;
        sel_byte   = 1'b1;
        sel_signed = (m.mem_sel == MEM_B);
        be_next    = 4'b0001 << m.mem_addr[1:0];
        wdata_next = {4{m.mem_wdata[7:0]}};
      end
      MEM_H, MEM_HU: begin
        is_mem     = 1'b1;
        sel_half   = 1'b1;
        sel_signed = (m.mem_sel == MEM_H);
        misaligned = m.mem_addr[0];
        be_next    = m.mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{m.mem_wdata[15:0]}};
      end
      MEM_W: begin
        is_mem     = 1'b1;
        misaligned = |m.mem_addr[1:0];
        be_next    = 4'b1111;
        wdata_next = m.mem_wdata;
      end
      default: ;
    endcase

    active  = (state == IDLE) && m.req_valid && is_mem;
    accept  = active && !misaligned;
    timeout = (state == REQ) && !m.bus_ack && (wait_cnt == CNT_LAST);

    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ;
      REQ:     if (m.bus_ack || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign m.stall = accept || (state == REQ);

  // Little-endian lane select on the captured address offset.
  always_comb begin
    lane_byte = m.bus_rdata[{cap_off, 3'b000} +: 8];
    lane_half = cap_off[1] ? m.bus_rdata[31:16] : m.bus_rdata[15:0];
    if (cap_byte)
      rd_ext = {{24{cap_signed & lane_byte[7]}}, lane_byte};
    else if (cap_half)
      rd_ext = {{16{cap_signed & lane_half[15]}}, lane_half};
    else
      rd_ext = m.bus_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt     <= '0;
      cap_off      <= 2'b00;
      cap_byte     <= 1'b0;
      cap_half     <= 1'b0;
      cap_signed   <= 1'b0;
      m.load_data  <= 32'h0;
      m.load_valid <= 1'b0;
      m.addr_err   <= 1'b0;
      m.bus_err    <= 1'b0;
      m.bus_req    <= 1'b0;
      m.bus_we     <= 1'b0;
      m.bus_addr   <= 32'h0;
      m.bus_be     <= 4'b0000;
      m.bus_wdata  <= 32'h0;
    end else begin
      m.addr_err   <= active && misaligned;
      m.load_valid <= 1'b0;
      m.bus_err    <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          m.bus_req   <= 1'b1;
          m.bus_we    <= m.mem_wen;
          m.bus_addr  <= {m.mem_addr[31:2], 2'b00};
          m.bus_be    <= be_next;
          m.bus_wdata <= wdata_next;
          cap_off     <= m.mem_addr[1:0];
          cap_byte    <= sel_byte;
          cap_half    <= sel_half;
          cap_signed  <= sel_signed;
          wait_cnt    <= '0;
        end
        REQ: begin
          if (m.bus_ack) begin
            m.bus_req    <= 1'b0;
            m.load_valid <= 1'b1;
            m.load_data  <= m.bus_we ? 32'h0 : rd_ext;
          end else if (timeout) begin
            m.bus_req   <= 1'b0;
            m.bus_err   <= 1'b1;
            m.load_data <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: table of single transactions plus hand-written
// timeout, no-op and mid-transaction reset sequences.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_if bus ();

  mem_access #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .m   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // k = wait cycles before ack (-1: never ack); mis = expected misalignment
  typedef struct {
    logic [2:0]  sel;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] ld;
  } vec_t;

  vec_t tbl [15];

  // Presents one request in cycle T and observes the following TO+4 cycles.
  task automatic run_txn(input vec_t v, input string tag);
    int stall_n = 0, req_n = 0, aerr_n = 0;
    int done_c = -1, err_c = -1, aerr_c = -1;
    logic [31:0] ld = 32'hx;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_sel   = v.sel;
    bus.mem_wen   = v.wen;
    bus.mem_addr  = v.addr;
    bus.mem_wdata = v.wdata;
    #1;
    if (bus.stall) stall_n++;
    for (int c = 1; c <= TO + 4; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_sel   = NOT_MEM;
      bus.bus_ack   = (c == v.k + 1);
      bus.bus_rdata = v.rdata;
      #1;
      if (bus.stall) stall_n++;
      if (bus.bus_req) begin
        req_n++;
        if (req_n == 1) begin
          check({tag, " bus_addr"},  bus.bus_addr,  {v.addr[31:2], 2'b00});
          check({tag, " bus_be"},    32'(bus.bus_be), 32'(v.be));
          check({tag, " bus_we"},    32'(bus.bus_we), 32'(v.wen));
          check({tag, " bus_wdata"}, bus.bus_wdata, v.bwdata);
        end
      end
      if (bus.addr_err) begin
        aerr_n++;
        if (aerr_c < 0) aerr_c = c;
      end
      if (bus.bus_err && err_c < 0) begin
        err_c = c;
        ld    = bus.load_data;
      end
      if (bus.load_valid && done_c < 0) begin
        done_c = c;
        ld     = bus.load_data;
      end
    end
    bus.bus_ack = 1'b0;

    if (v.mis) begin
      check({tag, " addr_err cycle"}, 32'(aerr_c), 32'd1);
      check({tag, " addr_err width"}, 32'(aerr_n), 32'd1);
      check({tag, " stall cycles"},   32'(stall_n), 32'd0);
      check({tag, " bus_req cycles"}, 32'(req_n), 32'd0);
      check({tag, " load_valid"},     32'(done_c), -32'sd1);
    end else if (v.k < 0) begin
      check({tag, " bus_err cycle"},  32'(err_c), 32'(TO + 1));
      check({tag, " load_valid"},     32'(done_c), -32'sd1);
      check({tag, " bus_req cycles"}, 32'(req_n), 32'(TO));
      check({tag, " stall cycles"},   32'(stall_n), 32'(TO + 1));
      check({tag, " load_data"},      ld, 32'h0);
    end else begin
      check({tag, " load_valid cycle"}, 32'(done_c), 32'(v.k + 2));
      check({tag, " bus_req cycles"},   32'(req_n), 32'(v.k + 1));
      check({tag, " stall cycles"},     32'(stall_n), 32'(v.k + 2));
      check({tag, " bus_err"},          32'(err_c), -32'sd1);
      check({tag, " addr_err"},         32'(aerr_n), 32'd0);
      if (!v.wen) check({tag, " load_data"}, ld, v.ld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv;
    //             sel     wen   addr        wdata         rdata         k   mis   be       bwdata        ld
    tbl[0]  = '{MEM_W,  1'b1, 32'h100, 32'hDEADBEEF, 32'h0,        0,  1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{MEM_B,  1'b1, 32'h103, 32'h000000A5, 32'h0,        0,  1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
    tbl[2]  = '{MEM_H,  1'b1, 32'h102, 32'h00001234, 32'h0,        1,  1'b0, 4'b1100, 32'h12341234, 32'h0};
    tbl[3]  = '{MEM_B,  1'b0, 32'h201, 32'h0,        32'h1122F344, 3,  1'b0, 4'b0010, 32'h0,        32'hFFFFFFF3};
    tbl[4]  = '{MEM_BU, 1'b0, 32'h201, 32'h0,        32'h1122F344, 3,  1'b0, 4'b0010, 32'h0,        32'h000000F3};
    tbl[5]  = '{MEM_H,  1'b0, 32'h202, 32'h0,        32'h1122F344, 3,  1'b0, 4'b1100, 32'h0,        32'h00001122};
    tbl[6]  = '{MEM_HU, 1'b0, 32'h200, 32'h0,        32'h0000F344, 3,  1'b0, 4'b0011, 32'h0,        32'h0000F344};
    tbl[7]  = '{MEM_H,  1'b0, 32'h200, 32'h0,        32'h0000F344, 3,  1'b0, 4'b0011, 32'h0,        32'hFFFFF344};
    tbl[8]  = '{MEM_W,  1'b0, 32'h302, 32'h0,        32'h0,        0,  1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[9]  = '{MEM_H,  1'b0, 32'h301, 32'h0,        32'h0,        0,  1'b1, 4'b0000, 32'h0,        32'h0};
    tbl[10] = '{MEM_W,  1'b0, 32'h304, 32'h0,        32'h89ABCDEF, 2,  1'b0, 4'b1111, 32'h0,        32'h89ABCDEF};
    tbl[11] = '{MEM_B,  1'b0, 32'h203, 32'h0,        32'h80000000, 0,  1'b0, 4'b1000, 32'h0,        32'hFFFFFF80};
    tbl[12] = '{MEM_HU, 1'b0, 32'h302, 32'h0,        32'h80010000, 1,  1'b0, 4'b1100, 32'h0,        32'h00008001};
    tbl[13] = '{MEM_B,  1'b1, 32'h101, 32'h123456C3, 32'h0,        2,  1'b0, 4'b0010, 32'hC3C3C3C3, 32'h0};
    tbl[14] = '{MEM_H,  1'b1, 32'h100, 32'hFFFF9876, 32'h0,        0,  1'b0, 4'b0011, 32'h98769876, 32'h0};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_sel   = NOT_MEM;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset stall",      32'(bus.stall), 32'd0);
    check("reset bus_req",    32'(bus.bus_req), 32'd0);
    check("reset load_valid", 32'(bus.load_valid), 32'd0);
    check("reset load_data",  bus.load_data, 32'h0);
    check("reset bus_addr",   bus.bus_addr, 32'h0);
    check("reset bus_be",     32'(bus.bus_be), 32'd0);
    check("reset bus_err",    32'(bus.bus_err), 32'd0);
    check("reset addr_err",   32'(bus.addr_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Timeout, then a normal request is still accepted
    tv = '{MEM_W, 1'b0, 32'h400, 32'h0, 32'h0, -1, 1'b0, 4'b1111, 32'h0, 32'h0};
    run_txn(tv, "timeout");
    run_txn(tbl[10], "after_timeout");

    // No-op requests
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_sel   = NOT_MEM;
    bus.mem_addr  = 32'h100;
    #1;
    check("not_mem stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    #1;
    check("not_mem bus_req",  32'(bus.bus_req), 32'd0);
    check("not_mem addr_err", 32'(bus.addr_err), 32'd0);
    bus.req_valid = 1'b0;
    bus.mem_sel   = MEM_W;
    #1;
    check("no_valid stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    #1;
    check("no_valid bus_req", 32'(bus.bus_req), 32'd0);
    bus.mem_sel = NOT_MEM;

    // Reset in the middle of a transaction; late ack must be ignored
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_sel   = MEM_W;
    bus.mem_wen   = 1'b1;
    bus.mem_addr  = 32'h500;
    bus.mem_wdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_sel   = NOT_MEM;
    #1;
    check("rst_mid bus_req before", 32'(bus.bus_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid bus_req",    32'(bus.bus_req), 32'd0);
    check("rst_mid stall",      32'(bus.stall), 32'd0);
    check("rst_mid bus_addr",   bus.bus_addr, 32'h0);
    check("rst_mid bus_wdata",  bus.bus_wdata, 32'h0);
    check("rst_mid bus_we",     32'(bus.bus_we), 32'd0);
    check("rst_mid load_valid", 32'(bus.load_valid), 32'd0);
    @(negedge clk);
    rst         = 1'b0;
    bus.bus_ack = 1'b1;
    @(negedge clk);
    bus.bus_ack = 1'b0;
    #1;
    check("late_ack load_valid", 32'(bus.load_valid), 32'd0);
    check("late_ack bus_err",    32'(bus.bus_err), 32'd0);
    check("late_ack stall",      32'(bus.stall), 32'd0);
    check("late_ack bus_req",    32'(bus.bus_req), 32'd0);
    @(negedge clk);
    #1;
    check("late_ack load_valid next", 32'(bus.load_valid), 32'd0);
    bus.mem_wen = 1'b0;
    run_txn(tbl[3], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
